// File: rtl/sync_dff_pkg.sv
// -----------------------------------------------------------------------------
// sync_dff_pkg
// Shared constants for the sync_dff register family.
//   SYNC_DFF_DEFAULT_WIDTH : default data width of sync_dff
//   SYNC_DFF_DEFAULT_RESET : default per-bit reset value (replicated to WIDTH)
//   SYNC_DFF_RST_STAGES    : depth of the reset-deassertion synchroniser
//                            used when SYNC_DFF_RST_SYNC_EN is defined
// -----------------------------------------------------------------------------
package sync_dff_pkg;

   localparam int         SYNC_DFF_DEFAULT_WIDTH = 1;
   localparam logic [0:0] SYNC_DFF_DEFAULT_RESET = 1'b0;
   localparam int         SYNC_DFF_RST_STAGES    = 2;

endpackage : sync_dff_pkg

// File: rtl/sync_dff_rst_sync.sv
// -----------------------------------------------------------------------------
// sync_dff_rst_sync
// Asynchronous-assert / synchronous-deassert reset synchroniser.
// Ports:
//   clk       in  1  clock the released reset is aligned to
//   rst_async in  1  raw active-high reset, may be asynchronous to clk
//   rst_sync  out 1  active-high reset; asserts immediately with rst_async,
//                    releases on the STAGES-th rising edge at which
//                    rst_async is sampled low
// -----------------------------------------------------------------------------
module sync_dff_rst_sync
   import sync_dff_pkg::*;
#(
   parameter int STAGES = SYNC_DFF_RST_STAGES
) (
   input  logic clk,
   input  logic rst_async,
   output logic rst_sync
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift a zero in from the bottom; the top stage is the released reset.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], 1'b0};
   end

   // Chain flops: fill with ones asynchronously, drain one stage per edge.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         chain_q <= {STAGES{1'b1}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign rst_sync = chain_q[STAGES-1];

endmodule : sync_dff_rst_sync

// File: rtl/sync_dff.sv
// -----------------------------------------------------------------------------
// sync_dff
// Parameterised D register with asynchronous active-high reset.
// Parameters:
//   WIDTH       data width in bits (>= 1)
//   RESET_VALUE value forced onto Q while reset is active
// Ports:
//   clk   in  1      rising-edge clock
//   D     in  WIDTH  data captured on every rising edge out of reset
//   reset in  1      asynchronous, active-high reset
//   Q     out WIDTH  registered data, driven straight from the flop
// Build option:
//   SYNC_DFF_RST_SYNC_EN  when defined, reset deassertion is passed through a
//                         two-flop synchroniser (assertion stays asynchronous),
//                         so Q first follows D on the 3rd edge after release.
// -----------------------------------------------------------------------------
module sync_dff
   import sync_dff_pkg::*;
#(
   parameter int               WIDTH       = SYNC_DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{SYNC_DFF_DEFAULT_RESET}}
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] D,
   input  logic             reset,
   output logic [WIDTH-1:0] Q
);

   logic             rst_int_s;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

`ifdef SYNC_DFF_RST_SYNC_EN
   // Raw reset may come from another domain: align its release to clk.
   sync_dff_rst_sync #(
      .STAGES    (SYNC_DFF_RST_STAGES)
   ) u_rst_sync (
      .clk       (clk),
      .rst_async (reset),
      .rst_sync  (rst_int_s)
   );
`else
   assign rst_int_s = reset;
`endif

   // No enable: every edge out of reset loads D.
   always_comb begin
      q_d = D;
   end

   // Data flop; reset wins over a coincident clock edge.
   always_ff @(posedge clk or posedge rst_int_s) begin
      if (rst_int_s) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule : sync_dff

// File: tb/tb_sync_dff.sv
// -----------------------------------------------------------------------------
// tb_sync_dff
// Directed bench for sync_dff: a 1-bit instance (RESET_VALUE 0) and an 8-bit
// instance (RESET_VALUE 8'hA5). Clock period 10, starting low, so rising
// edges occur at 5, 15, 25, ... Expected deassertion latency follows
// SYNC_DFF_RST_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_sync_dff;

   logic       clk;
   logic       d1;
   logic       rst1;
   logic       q1;
   logic [7:0] d8;
   logic       rst8;
   logic [7:0] q8;

   int checks;
   int failures;

   sync_dff #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_dut1 (
      .clk   (clk),
      .D     (d1),
      .reset (rst1),
      .Q     (q1)
   );

   sync_dff #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk   (clk),
      .D     (d8),
      .reset (rst8),
      .Q     (q8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to an absolute simulation time.
   task automatic at(input longint t);
      #(t - longint'($time));
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      d1   = 1'b0;
      rst1 = 1'b0;
      d8   = 8'h00;
      rst8 = 1'b0;

      at(2);  rst8 = 1'b1;
      at(3);  chk("w8_async_reset", q8, 8'hA5);
              d8 = 8'h3C;
`ifndef SYNC_DFF_RST_SYNC_EN
      at(6);  chk("w1_first_edge_d0", {7'd0, q1}, 8'h00);
`endif
      at(6);  chk("w8_hold_in_reset", q8, 8'hA5);
      at(8);  rst8 = 1'b0;
      at(10); d1 = 1'b1; rst1 = 1'b1;
      at(11); chk("w1_async_reset_midcycle", {7'd0, q1}, 8'h00);
      at(16); chk("w1_reset_holds_edge15", {7'd0, q1}, 8'h00);
`ifdef SYNC_DFF_RST_SYNC_EN
              chk("w8_sync_release_edge1", q8, 8'hA5);
`else
              chk("w8_load_after_release", q8, 8'h3C);
`endif
      at(20); rst1 = 1'b0;
`ifdef SYNC_DFF_RST_SYNC_EN
      at(26); chk("w1_sync_release_edge25", {7'd0, q1}, 8'h00);
              chk("w8_sync_release_edge2", q8, 8'hA5);
      at(36); chk("w1_sync_release_edge35", {7'd0, q1}, 8'h00);
              chk("w8_sync_load_3rd_edge", q8, 8'h3C);
      at(37); d8 = 8'hC3;
      at(46); chk("w1_sync_load_edge45", {7'd0, q1}, 8'h01);
              chk("w8_new_data", q8, 8'hC3);
      at(47); rst8 = 1'b1;
      at(48); chk("w8_async_reset_clk_high", q8, 8'hA5);
      at(50); rst1 = 1'b1;
      at(51); chk("w1_async_reset_again", {7'd0, q1}, 8'h00);
      at(56); chk("w1_reset_holds_edge55", {7'd0, q1}, 8'h00);
              chk("w8_reset_holds_edge55", q8, 8'hA5);
`else
      at(26); chk("w1_load_after_release", {7'd0, q1}, 8'h01);
      at(30); rst1 = 1'b1;
      at(31); chk("w1_async_reset_no_edge", {7'd0, q1}, 8'h00);
      at(36); chk("w1_reset_holds_edge35", {7'd0, q1}, 8'h00);
              chk("w8_hold_between", q8, 8'h3C);
      at(37); d8 = 8'hC3;
      at(40); rst1 = 1'b0; d1 = 1'b0;
      at(46); chk("w1_load_d0", {7'd0, q1}, 8'h00);
              chk("w8_new_data", q8, 8'hC3);
      at(47); rst8 = 1'b1;
      at(48); chk("w8_async_reset_clk_high", q8, 8'hA5);
      at(50); d1 = 1'b1;
      at(56); chk("w1_load_d1", {7'd0, q1}, 8'h01);
      at(58); d1 = 1'b0;
      at(59); chk("w1_hold_between_edges", {7'd0, q1}, 8'h01);
      at(66); chk("w1_load_d0_again", {7'd0, q1}, 8'h00);
              chk("w8_reset_holds_edge65", q8, 8'hA5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sync_dff
